// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared types and default widths for the sprite ROM arbiter.
// The owner tag identifies which requester a ROM read belongs to.
package sprite_rom_arbiter_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant logic: fixed p0 priority during active video, round-robin in
// blanking, with a starvation override that forces a p1 grant.
module rr_arb2
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   display_en,
    input  logic   p0_req,
    input  logic   p1_req,
    output logic   p0_gnt,
    output logic   p1_gnt,
    output logic   p1_forced,
    output owner_t winner
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] wait1;
    owner_t     last_owner;
    logic       force_p1;

    // Forcing is a blanking-only escape hatch; wait1 still counts during video.
    assign force_p1 = !display_en && p1_req && (wait1 >= LIMIT);

    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p1_forced = 1'b0;
        winner    = OWN_NONE;
        if (display_en) begin
            if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end else if (force_p1) begin
            p1_gnt    = 1'b1;
            p1_forced = 1'b1;
        end else if (p0_req && p1_req) begin
            if (last_owner == OWN_P0) begin
                p1_gnt = 1'b1;
            end else begin
                p0_gnt = 1'b1;
            end
        end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
        end
        if (p0_gnt) begin
            winner = OWN_P0;
        end else if (p1_gnt) begin
            winner = OWN_P1;
        end
    end

    // Reset owner to p1 so the first blanking tie goes to the renderer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait1      <= 8'd0;
            last_owner <= OWN_P1;
        end else begin
            if (p1_gnt) begin
                wait1 <= 8'd0;
            end else if (p1_req && (wait1 != 8'hFF)) begin
                wait1 <= wait1 + 8'd1;
            end
            if (p0_gnt) begin
                last_owner <= OWN_P0;
            end else if (p1_gnt) begin
                last_owner <= OWN_P1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM between the renderer (p0) and the overlay/UI (p1);
// an owner tag follows each read through the ROM latency to route the data.
module sprite_rom_arbiter
    import sprite_rom_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ROM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              display_en,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    input  logic              clr_stats,
    output logic [15:0]       deny_cnt,
    output logic              p1_forced
);

    owner_t winner;
    owner_t tag_pipe [ROM_LAT+1];

    rr_arb2 #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk       (vga_clk),
        .rst_n     (rst_n),
        .display_en(display_en),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p1_forced (p1_forced),
        .winner    (winner)
    );

    // Address register; the tag pipe is one stage per ROM cycle plus this one.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            for (int i = 0; i <= ROM_LAT; i++) begin
                tag_pipe[i] <= OWN_NONE;
            end
        end else begin
            if (p0_gnt) begin
                rom_addr <= p0_addr;
            end else if (p1_gnt) begin
                rom_addr <= p1_addr;
            end
            tag_pipe[0] <= winner;
            for (int i = 1; i <= ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Response stage: rom_q is steered by the tag that matured this cycle.
    assign p0_rvalid = (tag_pipe[ROM_LAT] == OWN_P0);
    assign p1_rvalid = (tag_pipe[ROM_LAT] == OWN_P1);
    assign p0_rdata  = p0_rvalid ? rom_q : '0;
    assign p1_rdata  = p1_rvalid ? rom_q : '0;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            deny_cnt <= 16'd0;
        end else if (clr_stats) begin
            deny_cnt <= 16'd0;
        end else if (p1_req && !p1_gnt && (deny_cnt != 16'hFFFF)) begin
            deny_cnt <= deny_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a response scoreboard and a
// registered ROM model of depth ROM_LAT.
module tb_sprite_rom_arbiter;
    import sprite_rom_arbiter_pkg::*;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 4;
    localparam int ROM_LAT      = 2;
    localparam int STARVE_LIMIT = 8;

    logic              vga_clk = 1'b0;
    logic              rst_n;
    logic              display_en;
    logic              p0_req, p1_req;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q, rom_s1, rom_s2;
    logic              clr_stats;
    logic [15:0]       deny_cnt;
    logic              p1_forced;

    typedef struct {
        logic            port;
        logic [DATA_W-1:0] data;
        int              cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .display_en(display_en),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .rom_addr(rom_addr), .rom_q(rom_q), .clr_stats(clr_stats),
        .deny_cnt(deny_cnt), .p1_forced(p1_forced)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ 4'hA;
    endfunction

    // ROM model: ROM_LAT registered stages after the address register.
    always @(posedge vga_clk) begin
        rom_s1 <= rom_fn(rom_addr);
        rom_s2 <= rom_s1;
    end
    assign rom_q = rom_s2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // Apply inputs just after an edge, then settle before sampling grants.
    task automatic drive(input logic de, input logic r0, input logic r1,
                         input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        tick();
        display_en = de;
        p0_req     = r0;
        p1_req     = r1;
        p0_addr    = a0;
        p1_addr    = a1;
        #3;
    endtask

    task automatic expect_gnt(input string nm, input logic g0, input logic g1, input logic frc);
        chk({nm, "_p0_gnt"}, 32'(p0_gnt), 32'(g0));
        chk({nm, "_p1_gnt"}, 32'(p1_gnt), 32'(g1));
        chk({nm, "_p1_forced"}, 32'(p1_forced), 32'(frc));
        if (g0) sb.push_back('{1'b0, rom_fn(p0_addr), cyc + ROM_LAT + 1});
        if (g1) sb.push_back('{1'b1, rom_fn(p1_addr), cyc + ROM_LAT + 1});
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge vga_clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_resp: got no rvalid, expected port %0d data %0h at cycle %0d", e.port, e.data, e.cyc);
            end
            if (p0_rvalid || p1_rvalid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got p0=%0b p1=%0b, expected none (cycle %0d)", p0_rvalid, p1_rvalid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_both", 32'(p0_rvalid & p1_rvalid), 32'd0);
                    chk("resp_port", 32'(p1_rvalid), 32'(e.port));
                    chk("resp_data", 32'(p1_rvalid ? p1_rdata : p0_rdata), 32'(e.data));
                    chk("resp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (!p0_rvalid) chk("p0_rdata_idle", 32'(p0_rdata), 32'd0);
            if (!p1_rvalid) chk("p1_rdata_idle", 32'(p1_rdata), 32'd0);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        display_en = 1'b0;
        p0_req     = 1'b0;
        p1_req     = 1'b0;
        p0_addr    = '0;
        p1_addr    = '0;
        clr_stats  = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) tick();
        #3;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_deny_cnt", 32'(deny_cnt), 32'd0);
        chk("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        chk("rst_p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rst_p1_forced", 32'(p1_forced), 32'd0);
        tick();
        rst_n = 1'b1;

        // Active video, both requesting: renderer always wins.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'h0100 + 16'(i), 16'h8000);
            expect_gnt("video_prio", 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("video_deny_cnt", 32'(deny_cnt), 32'd20);
        chk("video_rom_addr", 32'(rom_addr), 32'h0113);

        // Lone p1 request clears its starvation count.
        drive(1'b1, 1'b0, 1'b1, 16'h0, 16'h8001);
        expect_gnt("p1_alone", 1'b0, 1'b1, 1'b0);

        // Blanking, both requesting: strict alternation starting with p0.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b1, 16'h1000 + 16'(i), 16'h9000 + 16'(i));
            expect_gnt("rr_alt", (i % 2) == 0, (i % 2) == 1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("rr_deny_cnt", 32'(deny_cnt), 32'd25);

        // Seven denials: below the limit, p1 wins in blanking without forcing.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'h2000, 16'hA000);
            expect_gnt("starve7_video", 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 16'h2001, 16'hA001);
        expect_gnt("starve7_blank", 1'b0, 1'b1, 1'b0);

        // Eight denials: limit reached, forced grant pulses once.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'h2100, 16'hA100);
            expect_gnt("starve8_video", 1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b1, 16'h2101, 16'hA101);
        expect_gnt("starve8_forced", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 16'h2102, 16'hA102);
        expect_gnt("after_forced", 1'b1, 1'b0, 1'b0);

        // display_en toggling while reads are in flight.
        drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h4567);
        expect_gnt("toggle_a", 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 16'h89AB, 16'h4568);
        expect_gnt("toggle_b", 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 16'h89AC, 16'h4569);
        expect_gnt("toggle_c", 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("toggle_deny_cnt", 32'(deny_cnt), 32'd42);

        // ROM latency 2: grant at t, data 4'hA to p0 at t+3.
        drive(1'b1, 1'b1, 1'b0, 16'h0123, 16'h0);
        expect_gnt("lat_grant", 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("lat_rom_addr", 32'(rom_addr), 32'h0123);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("lat_p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("lat_p0_rdata", 32'(p0_rdata), 32'hA);
        chk("lat_p1_rvalid", 32'(p1_rvalid), 32'd0);
        repeat (4) drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("hold_rom_addr", 32'(rom_addr), 32'h0123);
        chk("drained", 32'(sb.size()), 32'd0);

        // Reset one cycle into a read: the read must vanish.
        drive(1'b1, 1'b1, 1'b0, 16'h0ABC, 16'h0);
        chk("rstread_gnt", 32'(p0_gnt), 32'd1);
        tick();
        rst_n  = 1'b0;
        p0_req = 1'b0;
        #3;
        chk("rstread_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("post_rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("post_rst_deny_cnt", 32'(deny_cnt), 32'd0);

        // First blanking tie after reset goes to p0.
        drive(1'b0, 1'b1, 1'b1, 16'h3000, 16'hB000);
        expect_gnt("first_tie", 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 16'h3001, 16'hB001);
        expect_gnt("second_tie", 1'b0, 1'b1, 1'b0);

        // Long denial run to saturate deny_cnt.
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 1'b1, 1'b1, 16'h0200, 16'hC000);
            expect_gnt("sat_run", 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("sat_deny_cnt", 32'(deny_cnt), 32'hFFFF);
        drive(1'b1, 1'b1, 1'b1, 16'h0201, 16'hC001);
        expect_gnt("sat_extra", 1'b1, 1'b0, 1'b0);
        clr_stats = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("sat_hold", 32'(deny_cnt), 32'hFFFF);

        // Clear coinciding with a denial: clear wins.
        drive(1'b1, 1'b1, 1'b1, 16'h0202, 16'hC002);
        expect_gnt("clr_deny", 1'b1, 1'b0, 1'b0);
        clr_stats = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        clr_stats = 1'b0;
        chk("clr_deny_cnt", 32'(deny_cnt), 32'd0);

        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
